// File: rtl/led_bounce_chaser.sv
// Single-LED chaser with its own step prescaler: bounces up/down the bank or wraps to LED 0.
// Optional CHASE_TRAIL_EN adds a registered previous position so a 2-LED comet is shown.
module led_bounce_chaser #(
  parameter int N_LEDS   = 8,
  parameter int PRESCALE = 4,
  localparam int POS_W   = $clog2(N_LEDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic [1:0]        speed,
  input  logic              hold,
  output logic [N_LEDS-1:0] led,
  output logic [POS_W-1:0]  pos,
  output logic              dir_dn,
  output logic              turn,
  output logic [1:0]        state_o
);

  localparam int CNT_W = $clog2(PRESCALE * 8);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LEDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN_UP = 2'd1, RUN_DN = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_LEDS-1:0]   led_q, led_d;
  logic                dir_q, dir_d;
  logic                turn_q, turn_d;
  logic [31:0]         period_m1;
  logic                tick;
  logic                step;

  // Longer period at higher speed codes; a lowered speed below the count ticks at once.
  assign period_m1 = (32'(PRESCALE) << speed) - 32'd1;
  assign tick      = (32'(cnt_q) >= period_m1);

`ifdef CHASE_TRAIL_EN
  logic [POS_W-1:0] prev_pos_q, prev_pos_d;
  logic             prev_vld_q, prev_vld_d;
`endif

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    turn_d  = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        pos_d = '0;
        cnt_d = '0;
        if (en) state_d = RUN_UP;
      end
      RUN_UP, RUN_DN: begin
        if (!en) begin
          state_d = IDLE;
          pos_d   = '0;
          cnt_d   = '0;
        end else if (!hold) begin
          if (tick) begin
            cnt_d = '0;
            step  = 1'b1;
            if (state_q == RUN_UP) begin
              if (pos_q != POS_LAST) begin
                pos_d = pos_q + POS_W'(1);
              end else if (!mode) begin
                state_d = RUN_DN;
                pos_d   = POS_LAST - POS_W'(1);
                turn_d  = 1'b1;
              end else begin
                pos_d  = '0;
                turn_d = 1'b1;
              end
            end else begin
              // Down leg never sits at the top, so switching to wrap is a plain step up.
              if (mode) begin
                state_d = RUN_UP;
                pos_d   = pos_q + POS_W'(1);
              end else if (pos_q != '0) begin
                pos_d = pos_q - POS_W'(1);
              end else begin
                state_d = RUN_UP;
                pos_d   = POS_W'(1);
                turn_d  = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = '0;
        cnt_d   = '0;
      end
    endcase

    dir_d = (state_d == RUN_DN);
    led_d = '0;
    if (state_d != IDLE) led_d[pos_d] = 1'b1;
  end

`ifdef CHASE_TRAIL_EN
  always_comb begin
    prev_pos_d = prev_pos_q;
    prev_vld_d = prev_vld_q;
    if (state_d == IDLE || state_q == IDLE) begin
      prev_pos_d = '0;
      prev_vld_d = 1'b0;
    end else if (step) begin
      prev_pos_d = pos_q;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pos_q <= '0;
      prev_vld_q <= 1'b0;
      led_q      <= '0;
    end else begin
      prev_pos_q <= prev_pos_d;
      prev_vld_q <= prev_vld_d;
      led_q      <= led_d | ((prev_vld_d && state_d != IDLE) ?
                             (N_LEDS'(1) << prev_pos_d) : '0);
    end
  end
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) led_q <= '0;
    else        led_q <= led_d;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      turn_q  <= turn_d;
    end
  end

  assign led     = led_q;
  assign pos     = pos_q;
  assign dir_dn  = dir_q;
  assign turn    = turn_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_led_bounce_chaser.sv
// Directed bench for led_bounce_chaser (N_LEDS=4, PRESCALE=2): the driver pushes the expected
// {led,pos,dir_dn,turn} for each cycle; a negedge monitor pops and compares.
module tb_led_bounce_chaser;

  logic       clk;
  logic       reset;
  logic       en;
  logic       mode;
  logic [1:0] speed;
  logic       hold;
  logic [3:0] led;
  logic [1:0] pos;
  logic       dir_dn;
  logic       turn;
  logic [1:0] state_o;

  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_pass;
  int         n_entry;
  logic       drv_done;

  led_bounce_chaser #(.N_LEDS(4), .PRESCALE(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .speed  (speed),
    .hold   (hold),
    .led    (led),
    .pos    (pos),
    .dir_dn (dir_dn),
    .turn   (turn),
    .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for the cycle following the next rising edge.
  task automatic ex(input logic [3:0] l, input logic [1:0] p, input logic d, input logic t);
    @(posedge clk);
    #2;
    exp_q.push_back({l, p, d, t});
  endtask

  task automatic exn(input int n, input logic [3:0] l, input logic [1:0] p,
                     input logic d, input logic t);
    for (int i = 0; i < n; i++) ex(l, p, d, t);
  endtask

  // Reset asserted mid-cycle: outputs must clear before any further clock edge.
  task automatic ex_rst();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(8'h00);
  endtask

  always @(negedge clk) begin
    logic [7:0] got;
    logic [7:0] want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {led, pos, dir_dn, turn};
      n_checks++;
      n_entry++;
      if (got === want) n_pass++;
      else $display("FAIL cycle_check #%0d: got led=%b pos=%0d dir_dn=%b turn=%b, want led=%b pos=%0d dir_dn=%b turn=%b",
                    n_entry, got[7:4], got[3:2], got[1], got[0],
                    want[7:4], want[3:2], want[1], want[0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_entry  = 0;
    drv_done = 1'b0;
    reset = 1'b0; en = 1'b1; mode = 1'b0; speed = 2'd0; hold = 1'b0;

    // Reset held with en=1: outputs stay clear.
    exn(3, 4'h0, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;

    // Bounce at speed 0: step every 2 clks.
    exn(2, 4'h1, 2'd0, 1'b0, 1'b0);
    exn(2, 4'h2, 2'd1, 1'b0, 1'b0);
    exn(2, 4'h4, 2'd2, 1'b0, 1'b0);
    exn(2, 4'h8, 2'd3, 1'b0, 1'b0);
    ex(4'h4, 2'd2, 1'b1, 1'b1);
    ex(4'h4, 2'd2, 1'b1, 1'b0);
    exn(2, 4'h2, 2'd1, 1'b1, 1'b0);
    exn(2, 4'h1, 2'd0, 1'b1, 1'b0);
    ex(4'h2, 2'd1, 1'b0, 1'b1);
    ex(4'h2, 2'd1, 1'b0, 1'b0);
    mode = 1'b1;

    // Wrap.
    exn(2, 4'h4, 2'd2, 1'b0, 1'b0);
    exn(2, 4'h8, 2'd3, 1'b0, 1'b0);
    ex(4'h1, 2'd0, 1'b0, 1'b1);
    ex(4'h1, 2'd0, 1'b0, 1'b0);
    mode = 1'b0;

    // Back to bounce, then switch to wrap on the down leg at pos 2.
    exn(2, 4'h2, 2'd1, 1'b0, 1'b0);
    exn(2, 4'h4, 2'd2, 1'b0, 1'b0);
    exn(2, 4'h8, 2'd3, 1'b0, 1'b0);
    ex(4'h4, 2'd2, 1'b1, 1'b1);
    mode = 1'b1;
    ex(4'h4, 2'd2, 1'b1, 1'b0);
    exn(2, 4'h8, 2'd3, 1'b0, 1'b0);
    ex(4'h1, 2'd0, 1'b0, 1'b1);
    mode = 1'b0;
    ex(4'h1, 2'd0, 1'b0, 1'b0);
    exn(2, 4'h2, 2'd1, 1'b0, 1'b0);
    ex(4'h4, 2'd2, 1'b0, 1'b0);

    // Disable at pos 2, then restart with a full period before the first step.
    en = 1'b0;
    exn(2, 4'h0, 2'd0, 1'b0, 1'b0);
    en = 1'b1;
    exn(2, 4'h1, 2'd0, 1'b0, 1'b0);
    ex(4'h2, 2'd1, 1'b0, 1'b0);
    en = 1'b0;
    ex(4'h0, 2'd0, 1'b0, 1'b0);
    en = 1'b1;
    speed = 2'd3;

    // Speed 3: 16 clks per step; hold for 10 clks delays the step by 10.
    exn(16, 4'h1, 2'd0, 1'b0, 1'b0);
    ex(4'h2, 2'd1, 1'b0, 1'b0);
    exn(5, 4'h2, 2'd1, 1'b0, 1'b0);
    hold = 1'b1;
    exn(10, 4'h2, 2'd1, 1'b0, 1'b0);
    hold = 1'b0;
    exn(10, 4'h2, 2'd1, 1'b0, 1'b0);
    ex(4'h4, 2'd2, 1'b0, 1'b0);

    // Speed drop to 0 with count at 9: step on the very next edge.
    exn(9, 4'h4, 2'd2, 1'b0, 1'b0);
    speed = 2'd0;
    exn(2, 4'h8, 2'd3, 1'b0, 1'b0);
    ex(4'h4, 2'd2, 1'b1, 1'b1);

    // Asynchronous reset mid-run, then release and restart.
    ex_rst();
    ex(4'h0, 2'd0, 1'b0, 1'b0);
    reset = 1'b1;
    exn(2, 4'h1, 2'd0, 1'b0, 1'b0);
    ex(4'h2, 2'd1, 1'b0, 1'b0);

    drv_done = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
